multicycle_control_unit: RTL and testbench
==========================================

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 SHALL have parameter BUS_TIMEOUT, default 15: max consecutive wait cycles on mem_ready before trap.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port Opcode  input  7  instruction opcode from instruction register.
REQ-005 SHALL have port Zero  input  1  ALU zero flag.
REQ-006 SHALL have port mem_ready  input  1  memory access complete this cycle.
REQ-007 SHALL have port PCWrite  output  1  PC register enable.
REQ-008 SHALL have port AdrSrc  output  1  memory address select: 0=PC, 1=ALUOut.
REQ-009 SHALL have port MemWrite  output  1  data store enable.
REQ-010 SHALL have port IRWrite  output  1  instruction register enable.
REQ-011 SHALL have port ResultSrc  output  2  00=ALUOut, 01=read data, 10=ALU result.
REQ-012 SHALL have port ALUSrcA  output  2  00=PC, 01=OldPC, 10=rs1.
REQ-013 SHALL have port ALUSrcB  output  2  00=rs2, 01=ImmExt, 10=constant 4.
REQ-014 SHALL have port ALU_Op  output  2  to ALU decoder: 00=add, 01=sub, 10=R-type, 11=I-type.
REQ-015 SHALL have port RegWrite  output  1  register file write enable.
REQ-016 SHALL have ports retire output 1 (one-cycle pulse per completed instruction), trap output 1, trap_cause output 2 (01=illegal opcode, 10=bus timeout), state output 4 (debug).

Function
REQ-017 States/encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10, TRAP=11; codes 12-15 SHALL go to TRAP with cause 01.
REQ-018 Outputs SHALL be decoded from state (plus mem_ready/Zero where stated); any output not listed for a state is 0.
REQ-019 FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALU_Op=00, ResultSrc=10; IRWrite=PCWrite=mem_ready; -> DECODE when mem_ready=1, else hold.
REQ-020 DECODE: ALUSrcA=01, ALUSrcB=01, ALU_Op=00; next by Opcode: 0000011/0100011->MEMADR, 0110011->EXECUTER, 0010011->EXECUTEI, 1100011->BEQ, 1101111->JAL, other->TRAP cause 01.
REQ-021 MEMADR: ALUSrcA=10, ALUSrcB=01, ALU_Op=00; -> MEMREAD if Opcode=0000011, else MEMWRITE.
REQ-022 MEMREAD: AdrSrc=1, ResultSrc=00; -> MEMWB on mem_ready, else hold.
REQ-023 MEMWB: ResultSrc=01, RegWrite=1, retire=1; -> FETCH.
REQ-024 MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 held every cycle until mem_ready; retire=mem_ready; -> FETCH on mem_ready.
REQ-025 EXECUTER: ALUSrcA=10, ALUSrcB=00, ALU_Op=10 -> ALUWB; EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALU_Op=11 -> ALUWB.
REQ-026 ALUWB: ResultSrc=00, RegWrite=1, retire=1; -> FETCH.
REQ-027 BEQ: ALUSrcA=10, ALUSrcB=00, ALU_Op=01, ResultSrc=00, PCWrite=Zero, retire=1; -> FETCH.
REQ-028 JAL: ALUSrcA=01, ALUSrcB=10, ALU_Op=00, ResultSrc=00, PCWrite=1; -> ALUWB.
REQ-029 Wait counter: clears on every state change; increments each cycle in FETCH/MEMREAD/MEMWRITE with mem_ready=0, saturating; when it equals BUS_TIMEOUT with mem_ready=0, next state TRAP, cause 10; mem_ready=1 in that same cycle wins (normal advance).
REQ-030 TRAP: all enables 0, trap=1, trap_cause held; exits only via rst.
REQ-031 Latencies (mem_ready=1 always): lw 5, sw 4, R/I-type 4, beq 3, jal 4 cycles.

Reset
REQ-032 rst=1 at a rising edge SHALL load state=FETCH, clear wait counter, trap=0, trap_cause=00, from any state including mid-instruction and TRAP.
REQ-033 While rst=1, PCWrite, IRWrite, MemWrite, RegWrite, retire SHALL be forced 0 combinationally; the other outputs take FETCH values.

Verification
REQ-034 lw (0000011), mem_ready=1 -> states 0,1,2,3,4; RegWrite=1, ResultSrc=01, retire=1 on cycle 5.
REQ-035 add (0110011) -> 0,1,6,8; ALU_Op=10 in EXECUTER; RegWrite=1 in ALUWB; addi gives ALU_Op=11, ALUSrcB=01.
REQ-036 beq with Zero=1 -> PCWrite=1 in BEQ; repeat with Zero=0 -> PCWrite=0; both retire after 3 cycles.
REQ-037 FETCH with mem_ready low 3 cycles -> state holds 0, IRWrite=PCWrite=0; 4th cycle mem_ready=1 -> IRWrite=PCWrite=1, DECODE next.
REQ-038 mem_ready held low in MEMWRITE -> MemWrite=1 throughout, TRAP with trap_cause=10 after 15 wait cycles; Opcode 1111111 in DECODE -> TRAP, trap_cause=01.
REQ-039 rst pulsed in MEMREAD and in TRAP -> next state FETCH, trap=0, no write enable asserted during rst.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multicycle RISC-V style control FSM with memory wait handshake, bus timeout
// detection and a sticky trap state that only reset can leave.
module multicycle_control_unit #(
  parameter int BUS_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] Opcode,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALU_Op,
  output logic       RegWrite,
  output logic       retire,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic [3:0] state
);

  localparam int CW = (BUS_TIMEOUT < 1) ? 1 : $clog2(BUS_TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_CNT = CW'(BUS_TIMEOUT);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_TRAP     = 4'd11;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  logic [3:0]    state_r;
  logic [3:0]    next_state_s;
  logic [3:0]    eff_state_s;
  logic [CW-1:0] wait_cnt_r;
  logic [1:0]    trap_cause_r;
  logic [1:0]    next_cause_s;
  logic          waiting_s;
  logic          timeout_s;
  logic          pcwrite_s;
  logic          memwrite_s;
  logic          irwrite_s;
  logic          regwrite_s;
  logic          retire_s;

  assign waiting_s = ((state_r == S_FETCH) || (state_r == S_MEMREAD) ||
                      (state_r == S_MEMWRITE)) && !mem_ready;
  assign timeout_s = waiting_s && (wait_cnt_r == TIMEOUT_CNT);

  // State, wait counter and trap cause registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_FETCH;
      wait_cnt_r   <= '0;
      trap_cause_r <= CAUSE_NONE;
    end else begin
      state_r      <= next_state_s;
      trap_cause_r <= next_cause_s;
      if (next_state_s != state_r) begin
        wait_cnt_r <= '0;
      end else if (waiting_s && (wait_cnt_r != TIMEOUT_CNT)) begin
        wait_cnt_r <= wait_cnt_r + CNT_ONE;
      end else begin
        wait_cnt_r <= wait_cnt_r;
      end
    end
  end

  // Next-state selection; trap cause is captured only on entry to TRAP
  always_comb begin
    next_state_s = state_r;
    next_cause_s = trap_cause_r;
    case (state_r)
      S_FETCH, S_MEMREAD, S_MEMWRITE: begin
        if (mem_ready) begin
          if (state_r == S_FETCH) begin
            next_state_s = S_DECODE;
          end else if (state_r == S_MEMREAD) begin
            next_state_s = S_MEMWB;
          end else begin
            next_state_s = S_FETCH;
          end
        end else if (timeout_s) begin
          next_state_s = S_TRAP;
          next_cause_s = CAUSE_TIMEOUT;
        end else begin
          next_state_s = state_r;
        end
      end
      S_DECODE: begin
        case (Opcode)
          OP_LOAD, OP_STORE: next_state_s = S_MEMADR;
          OP_RTYPE:          next_state_s = S_EXECUTER;
          OP_ITYPE:          next_state_s = S_EXECUTEI;
          OP_BEQ:            next_state_s = S_BEQ;
          OP_JAL:            next_state_s = S_JAL;
          default: begin
            next_state_s = S_TRAP;
            next_cause_s = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_MEMADR: begin
        if (Opcode == OP_LOAD) begin
          next_state_s = S_MEMREAD;
        end else begin
          next_state_s = S_MEMWRITE;
        end
      end
      S_MEMWB, S_ALUWB, S_BEQ: next_state_s = S_FETCH;
      S_EXECUTER, S_EXECUTEI, S_JAL: next_state_s = S_ALUWB;
      S_TRAP: next_state_s = S_TRAP;
      default: begin
        next_state_s = S_TRAP;
        next_cause_s = CAUSE_ILLEGAL;
      end
    endcase
  end

  // During reset the datapath controls show FETCH while all enables stay low
  assign eff_state_s = rst ? S_FETCH : state_r;

  // Output decode from the (reset-overridden) state
  always_comb begin
    pcwrite_s  = 1'b0;
    AdrSrc     = 1'b0;
    memwrite_s = 1'b0;
    irwrite_s  = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALU_Op     = 2'b00;
    regwrite_s = 1'b0;
    retire_s   = 1'b0;
    trap       = 1'b0;
    case (eff_state_s)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        irwrite_s = mem_ready;
        pcwrite_s = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc  = 2'b01;
        regwrite_s = 1'b1;
        retire_s   = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc     = 1'b1;
        memwrite_s = 1'b1;
        retire_s   = mem_ready;
      end
      S_EXECUTER: begin
        ALUSrcA = 2'b10;
        ALU_Op  = 2'b10;
      end
      S_EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALU_Op  = 2'b11;
      end
      S_ALUWB: begin
        regwrite_s = 1'b1;
        retire_s   = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA   = 2'b10;
        ALU_Op    = 2'b01;
        pcwrite_s = Zero;
        retire_s  = 1'b1;
      end
      S_JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pcwrite_s = 1'b1;
      end
      S_TRAP: trap = 1'b1;
      default: trap = 1'b0;
    endcase
  end

  assign PCWrite    = pcwrite_s  & ~rst;
  assign MemWrite   = memwrite_s & ~rst;
  assign IRWrite    = irwrite_s  & ~rst;
  assign RegWrite   = regwrite_s & ~rst;
  assign retire     = retire_s   & ~rst;
  assign trap_cause = rst ? CAUSE_NONE : trap_cause_r;
  assign state      = eff_state_s;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed table-driven bench for multicycle_control_unit plus hand-written
// sequences for wait/timeout, illegal opcode and reset corner cases.
module tb_multicycle_control_unit;

  logic       clk;
  logic       rst;
  logic [6:0] Opcode;
  logic       Zero;
  logic       mem_ready;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, retire, trap;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALU_Op, trap_cause;
  logic [3:0] state;
  logic [20:0] obs;

  int n_cmp;
  int n_bad;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] ILL = 7'b1111111;

  typedef struct packed {
    logic        rst;
    logic [6:0]  op;
    logic        z;
    logic        mr;
    logic [20:0] e;
  } vec_t;

  vec_t tbl[$];

  multicycle_control_unit #(.BUS_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .Opcode(Opcode), .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALU_Op(ALU_Op),
    .RegWrite(RegWrite), .retire(retire), .trap(trap), .trap_cause(trap_cause),
    .state(state)
  );

  assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                ALU_Op, RegWrite, retire, trap, trap_cause, state};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [20:0] ex(input logic [3:0] st, input logic pcw, adr, mw, irw,
                                     input logic [1:0] rs, sa, sb, aop,
                                     input logic rw, ret, trp, input logic [1:0] cause);
    return {pcw, adr, mw, irw, rs, sa, sb, aop, rw, ret, trp, cause, st};
  endfunction

  function automatic vec_t v(input logic r, input logic [6:0] op, input logic z,
                             input logic mr, input logic [20:0] e);
    vec_t t;
    t.rst = r; t.op = op; t.z = z; t.mr = mr; t.e = e;
    return t;
  endfunction

  // Drive inputs just after a falling edge, check 1 ns later, advance to next falling edge
  task automatic run(input string name, input logic r, input logic [6:0] op,
                     input logic z, input logic mr, input logic [20:0] e);
    rst = r; Opcode = op; Zero = z; mem_ready = mr;
    #1;
    n_cmp++;
    if (obs !== e) begin
      n_bad++;
      $display("FAIL %s: got %b want %b (pcw adr mw irw rs sa sb aop rw ret trap cause state)",
               name, obs, e);
    end
    @(negedge clk);
  endtask

  logic [20:0] e_f0, e_f1, e_dec, e_ma, e_mr, e_mwb, e_mw1, e_mw0, e_exr, e_exi;
  logic [20:0] e_awb, e_bq1, e_bq0, e_jal, e_t01, e_t10;

  initial begin
    n_cmp = 0; n_bad = 0;
    rst = 1'b1; Opcode = 7'd0; Zero = 1'b0; mem_ready = 1'b0;

    //             st     pcw   adr   mw    irw   rs     sa     sb     aop    rw    ret   trap  cause
    e_f0  = ex(4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00);
    e_f1  = ex(4'd0,  1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00);
    e_dec = ex(4'd1,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00);
    e_ma  = ex(4'd2,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00);
    e_mr  = ex(4'd3,  1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00);
    e_mwb = ex(4'd4,  1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 2'b00);
    e_mw1 = ex(4'd5,  1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00);
    e_mw0 = ex(4'd5,  1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00);
    e_exr = ex(4'd6,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 2'b00);
    e_exi = ex(4'd7,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b11, 1'b0, 1'b0, 1'b0, 2'b00);
    e_awb = ex(4'd8,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 2'b00);
    e_bq1 = ex(4'd9,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0, 2'b00);
    e_bq0 = ex(4'd9,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0, 2'b00);
    e_jal = ex(4'd10, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00);
    e_t01 = ex(4'd11, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 2'b01);
    e_t10 = ex(4'd11, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 2'b10);

    // reset (mem_ready=1 must not leak through to the enables)
    tbl.push_back(v(1'b1, LW, 1'b0, 1'b1, e_f0));
    tbl.push_back(v(1'b1, LW, 1'b0, 1'b0, e_f0));
    // lw: 0,1,2,3,4
    tbl.push_back(v(1'b0, LW, 1'b0, 1'b1, e_f1));
    tbl.push_back(v(1'b0, LW, 1'b0, 1'b1, e_dec));
    tbl.push_back(v(1'b0, LW, 1'b0, 1'b1, e_ma));
    tbl.push_back(v(1'b0, LW, 1'b0, 1'b1, e_mr));
    tbl.push_back(v(1'b0, LW, 1'b0, 1'b1, e_mwb));
    // add: 0,1,6,8
    tbl.push_back(v(1'b0, RT, 1'b0, 1'b1, e_f1));
    tbl.push_back(v(1'b0, RT, 1'b0, 1'b1, e_dec));
    tbl.push_back(v(1'b0, RT, 1'b0, 1'b1, e_exr));
    tbl.push_back(v(1'b0, RT, 1'b0, 1'b1, e_awb));
    // addi: 0,1,7,8
    tbl.push_back(v(1'b0, IT, 1'b0, 1'b1, e_f1));
    tbl.push_back(v(1'b0, IT, 1'b0, 1'b1, e_dec));
    tbl.push_back(v(1'b0, IT, 1'b0, 1'b1, e_exi));
    tbl.push_back(v(1'b0, IT, 1'b0, 1'b1, e_awb));
    // beq taken then not taken
    tbl.push_back(v(1'b0, BQ, 1'b1, 1'b1, e_f1));
    tbl.push_back(v(1'b0, BQ, 1'b1, 1'b1, e_dec));
    tbl.push_back(v(1'b0, BQ, 1'b1, 1'b1, e_bq1));
    tbl.push_back(v(1'b0, BQ, 1'b0, 1'b1, e_f1));
    tbl.push_back(v(1'b0, BQ, 1'b0, 1'b1, e_dec));
    tbl.push_back(v(1'b0, BQ, 1'b0, 1'b1, e_bq0));
    // jal: 0,1,10,8
    tbl.push_back(v(1'b0, JL, 1'b0, 1'b1, e_f1));
    tbl.push_back(v(1'b0, JL, 1'b0, 1'b1, e_dec));
    tbl.push_back(v(1'b0, JL, 1'b0, 1'b1, e_jal));
    tbl.push_back(v(1'b0, JL, 1'b0, 1'b1, e_awb));
    // sw: 0,1,2,5
    tbl.push_back(v(1'b0, SW, 1'b0, 1'b1, e_f1));
    tbl.push_back(v(1'b0, SW, 1'b0, 1'b1, e_dec));
    tbl.push_back(v(1'b0, SW, 1'b0, 1'b1, e_ma));
    tbl.push_back(v(1'b0, SW, 1'b0, 1'b1, e_mw1));
    // fetch stalled 3 cycles, then proceeds with an R-type
    tbl.push_back(v(1'b0, RT, 1'b0, 1'b0, e_f0));
    tbl.push_back(v(1'b0, RT, 1'b0, 1'b0, e_f0));
    tbl.push_back(v(1'b0, RT, 1'b0, 1'b0, e_f0));
    tbl.push_back(v(1'b0, RT, 1'b0, 1'b1, e_f1));
    tbl.push_back(v(1'b0, RT, 1'b0, 1'b1, e_dec));
    tbl.push_back(v(1'b0, RT, 1'b0, 1'b1, e_exr));
    tbl.push_back(v(1'b0, RT, 1'b0, 1'b1, e_awb));
    // lw with a 2-cycle memory stall
    tbl.push_back(v(1'b0, LW, 1'b0, 1'b1, e_f1));
    tbl.push_back(v(1'b0, LW, 1'b0, 1'b1, e_dec));
    tbl.push_back(v(1'b0, LW, 1'b0, 1'b1, e_ma));
    tbl.push_back(v(1'b0, LW, 1'b0, 1'b0, e_mr));
    tbl.push_back(v(1'b0, LW, 1'b0, 1'b0, e_mr));
    tbl.push_back(v(1'b0, LW, 1'b0, 1'b1, e_mr));
    tbl.push_back(v(1'b0, LW, 1'b0, 1'b1, e_mwb));

    @(negedge clk);
    foreach (tbl[i]) begin
      run($sformatf("vec%0d", i), tbl[i].rst, tbl[i].op, tbl[i].z, tbl[i].mr, tbl[i].e);
    end

    // sw with mem_ready stuck low: 16 cycles in MEMWRITE, then bus-timeout trap
    run("sw_fetch", 1'b0, SW, 1'b0, 1'b1, e_f1);
    run("sw_decode", 1'b0, SW, 1'b0, 1'b1, e_dec);
    run("sw_memadr", 1'b0, SW, 1'b0, 1'b1, e_ma);
    for (int k = 0; k < 16; k++) run($sformatf("sw_wait%0d", k), 1'b0, SW, 1'b0, 1'b0, e_mw0);
    for (int k = 0; k < 3; k++) run($sformatf("trap_timeout%0d", k), 1'b0, SW, 1'b0, 1'b1, e_t10);

    // reset out of TRAP
    run("rst_in_trap", 1'b1, LW, 1'b1, 1'b1, e_f0);
    run("after_trap_rst", 1'b0, LW, 1'b0, 1'b0, e_f0);

    // illegal opcode
    run("ill_fetch", 1'b0, ILL, 1'b0, 1'b1, e_f1);
    run("ill_decode", 1'b0, ILL, 1'b0, 1'b1, e_dec);
    run("trap_illegal0", 1'b0, ILL, 1'b0, 1'b1, e_t01);
    run("trap_illegal1", 1'b0, LW, 1'b0, 1'b0, e_t01);

    // fetch waits exactly BUS_TIMEOUT cycles; mem_ready on the limit cycle wins
    run("rst_pre_limit", 1'b1, LW, 1'b0, 1'b0, e_f0);
    for (int k = 0; k < 15; k++) run($sformatf("fetch_wait%0d", k), 1'b0, LW, 1'b0, 1'b0, e_f0);
    run("fetch_limit_ready", 1'b0, LW, 1'b0, 1'b1, e_f1);
    run("limit_decode", 1'b0, LW, 1'b0, 1'b1, e_dec);

    // reset mid-instruction in MEMREAD
    run("lw2_memadr", 1'b0, LW, 1'b0, 1'b1, e_ma);
    run("lw2_memread", 1'b0, LW, 1'b0, 1'b0, e_mr);
    run("rst_in_memread", 1'b1, LW, 1'b1, 1'b1, e_f0);
    run("after_memread_rst", 1'b0, LW, 1'b0, 1'b0, e_f0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
